// File: rtl/modulo_encaixotamento_duzias.sv
`default_nettype none
// ============================================================================
// Module   : modulo_encaixotamento_duzias
// Purpose  : Packs sealed bottles into boxes of BOTTLES_PER_BOX, drives box
//            feed/eject, tracks empty-box stock and completed boxes, and
//            back-pressures the sealing stage. Optional macro:
//            CAIXA_TIMEOUT_EN (eject watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module modulo_encaixotamento_duzias #(
    parameter int BOTTLES_PER_BOX = 12,
    parameter int STOCK_MAX       = 20,
    parameter int EJECT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       bottle_in_i,
    input  logic       box_present_i,
    input  logic       stock_load_i,
    input  logic [4:0] stock_in_i,
    output logic       box_feed_o,
    output logic       box_eject_o,
    output logic       hold_o,
    output logic       al_caixa_o,
    output logic       err_drop_o,
    output logic [3:0] bottle_count_o,
    output logic [6:0] box_count_o,
    output logic [4:0] box_stock_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        FILL  = 2'b10,
        EJECT = 2'b11
    } state_t;

    localparam int               c_ej_w      = $clog2(EJECT_CYCLES + 1);
    localparam logic [c_ej_w-1:0] c_ej_last  = c_ej_w'(EJECT_CYCLES - 1);
    localparam logic [c_ej_w-1:0] c_ej_one   = c_ej_w'(1);
    localparam logic [3:0]       c_bpb       = 4'(BOTTLES_PER_BOX);
    localparam logic [4:0]       c_stock_max = 5'(STOCK_MAX);

    generate
        if (BOTTLES_PER_BOX < 2 || BOTTLES_PER_BOX > 15 || STOCK_MAX < 0 ||
            STOCK_MAX > 31 || EJECT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("modulo_encaixotamento_duzias: illegal parameter set");
        end
    endgenerate

    state_t              state_q;
    logic                bottle_prev_q;
    logic                present_prev_q;
    logic                pending_q;
    logic                box_feed_q;
    logic                eject_q;
    logic                eject_done_q;
    logic [c_ej_w-1:0]   eject_cnt_q;
    logic [3:0]          bottle_cnt_q;
    logic [6:0]          box_cnt_q;
    logic [4:0]          stock_q;
    logic                err_drop_q;

    logic                w_rise;
    logic                w_present_rise;
    logic                w_hold;
    logic                w_stock_alarm;
    logic [4:0]          w_stock_load_val;

    assign w_rise           = bottle_in_i & ~bottle_prev_q;
    assign w_present_rise   = box_present_i & ~present_prev_q;
    assign w_hold           = ~(enable_i && (state_q == FILL));
    assign w_stock_alarm    = (state_q == LOAD) && (stock_q == 5'd0) && !box_present_i;
    assign w_stock_load_val = (stock_in_i > c_stock_max) ? c_stock_max : stock_in_i;

`ifdef CAIXA_TIMEOUT_EN
    localparam int               c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);

    logic [c_to_w-1:0] to_cnt_q;
    logic              w_to_alarm;

    assign w_to_alarm  = (to_cnt_q == c_to_max);
    assign al_caixa_o  = w_stock_alarm | w_to_alarm;
    assign box_eject_o = (eject_q | w_to_alarm) & enable_i;
`else
    assign al_caixa_o  = w_stock_alarm;
    assign box_eject_o = eject_q & enable_i;
`endif

    assign box_feed_o     = box_feed_q;
    assign hold_o         = w_hold;
    assign err_drop_o     = err_drop_q;
    assign bottle_count_o = bottle_cnt_q;
    assign box_count_o    = box_cnt_q;
    assign box_stock_o    = stock_q;
    assign state_o        = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bottle_prev_q  <= 1'b0;
            present_prev_q <= 1'b0;
            pending_q      <= 1'b0;
            box_feed_q     <= 1'b0;
            eject_q        <= 1'b0;
            eject_done_q   <= 1'b0;
            eject_cnt_q    <= '0;
            bottle_cnt_q   <= 4'd0;
            box_cnt_q      <= 7'd0;
            stock_q        <= 5'd0;
            err_drop_q     <= 1'b0;
`ifdef CAIXA_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            bottle_prev_q  <= bottle_in_i;
            present_prev_q <= box_present_i;
            box_feed_q     <= 1'b0;

            // A bottle released against backpressure is lost, never counted.
            if (w_rise && w_hold) begin
                err_drop_q <= 1'b1;
            end
            if (stock_load_i) begin
                stock_q <= w_stock_load_val;
            end

            if (enable_i) begin
                if (w_present_rise) begin
                    pending_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        if (box_present_i) begin
                            state_q <= FILL;
                        end else if (stock_q != 5'd0 && !pending_q && !stock_load_i) begin
                            box_feed_q <= 1'b1;
                            stock_q    <= stock_q - 5'd1;
                            pending_q  <= 1'b1;
                        end
                    end
                    FILL: begin
                        // Box lost: keep the partial count for the next box.
                        if (!box_present_i) begin
                            state_q <= LOAD;
                        end else if (w_rise) begin
                            bottle_cnt_q <= bottle_cnt_q + 4'd1;
                            if (bottle_cnt_q + 4'd1 == c_bpb) begin
                                state_q      <= EJECT;
                                eject_q      <= 1'b1;
                                eject_cnt_q  <= c_ej_last;
                                eject_done_q <= 1'b0;
                            end
                        end
                    end
                    EJECT: begin
                        if (!eject_done_q) begin
                            if (eject_cnt_q != '0) begin
                                eject_cnt_q <= eject_cnt_q - c_ej_one;
                            end else begin
                                eject_q      <= 1'b0;
                                eject_done_q <= 1'b1;
                            end
                        end else if (!box_present_i) begin
                            box_cnt_q    <= (box_cnt_q == 7'd99) ? 7'd0 : box_cnt_q + 7'd1;
                            bottle_cnt_q <= 4'd0;
                            eject_done_q <= 1'b0;
                            state_q      <= LOAD;
`ifdef CAIXA_TIMEOUT_EN
                            to_cnt_q     <= '0;
                        end else if (!w_to_alarm) begin
                            to_cnt_q     <= to_cnt_q + c_to_one;
`endif
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modulo_encaixotamento_duzias.sv
`default_nettype none
// Testbench for modulo_encaixotamento_duzias: scenario tasks with a scoreboard
// of expected bottle and box counts.
module tb_modulo_encaixotamento_duzias;

    logic       clk = 1'b0;
    logic       rst, enable, bottle_in, box_present, stock_load;
    logic [4:0] stock_in;
    logic       box_feed, box_eject, hold, al_caixa, err_drop;
    logic [3:0] bottle_count;
    logic [6:0] box_count;
    logic [4:0] box_stock;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int m_boxes  = 0;
    int exp_bottles[$];
    int exp_boxes[$];

    always #5 clk = ~clk;

    modulo_encaixotamento_duzias dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .bottle_in_i    (bottle_in),
        .box_present_i  (box_present),
        .stock_load_i   (stock_load),
        .stock_in_i     (stock_in),
        .box_feed_o     (box_feed),
        .box_eject_o    (box_eject),
        .hold_o         (hold),
        .al_caixa_o     (al_caixa),
        .err_drop_o     (err_drop),
        .bottle_count_o (bottle_count),
        .box_count_o    (box_count),
        .box_stock_o    (box_stock),
        .state_o        (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bottles(input int from, input int to);
        int e;
        for (int i = from; i <= to; i++) begin
            bottle_in = 1'b1;
            exp_bottles.push_back(i);
            tick();
            e = exp_bottles.pop_front();
            n_checks++; if (bottle_count !== 4'(e)) $display("FAIL bottle_count got %0d expected %0d", bottle_count, e); else n_pass++;
            bottle_in = 1'b0;
            if (i != to) tick();
        end
    endtask

    task automatic complete_box();
        int e;
        box_present = 1'b0;
        m_boxes = (m_boxes == 99) ? 0 : m_boxes + 1;
        exp_boxes.push_back(m_boxes);
        tick();
        e = exp_boxes.pop_front();
        n_checks++; if (box_count !== 7'(e)) $display("FAIL box_count got %0d expected %0d", box_count, e); else n_pass++;
        n_checks++; if (state !== 2'd1) $display("FAIL done_state got %0d expected 1", state); else n_pass++;
        n_checks++; if (bottle_count !== 4'd0) $display("FAIL done_bottles got %0d expected 0", bottle_count); else n_pass++;
    endtask

    task automatic do_box();
        int hi;
        box_present = 1'b1;
        tick();
        n_checks++; if (state !== 2'd2) $display("FAIL box_fill_state got %0d expected 2", state); else n_pass++;
        fill_bottles(1, 12);
        n_checks++; if (state !== 2'd3) $display("FAIL box_eject_state got %0d expected 3", state); else n_pass++;
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            if (box_eject === 1'b1) hi++;
            tick();
        end
        n_checks++; if (hi != 4) $display("FAIL eject_width got %0d expected 4", hi); else n_pass++;
        complete_box();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; bottle_in = 1'b0; box_present = 1'b0;
        stock_load = 1'b0; stock_in = 5'd0;
        tick(); tick();
        n_checks++; if (state !== 2'd0) $display("FAIL rst_state got %0d expected 0", state); else n_pass++;
        n_checks++; if (hold !== 1'b1) $display("FAIL rst_hold got %0d expected 1", hold); else n_pass++;
        n_checks++; if ({box_feed, box_eject, al_caixa, err_drop} !== 4'b0) $display("FAIL rst_flags got %b expected 0000", {box_feed, box_eject, al_caixa, err_drop}); else n_pass++;
        n_checks++; if ({bottle_count, box_count, box_stock} !== 16'd0) $display("FAIL rst_counters got %0d expected 0", {bottle_count, box_count, box_stock}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_feed_and_fill();
        int feeds;
        stock_load = 1'b1; stock_in = 5'd3;
        tick();
        stock_load = 1'b0; enable = 1'b1;
        tick();
        n_checks++; if (state !== 2'd1) $display("FAIL feed_load_state got %0d expected 1", state); else n_pass++;
        tick();
        n_checks++; if (box_feed !== 1'b1) $display("FAIL feed_pulse got %0d expected 1", box_feed); else n_pass++;
        n_checks++; if (box_stock !== 5'd2) $display("FAIL feed_stock got %0d expected 2", box_stock); else n_pass++;
        feeds = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (box_feed === 1'b1) feeds++;
        end
        n_checks++; if (feeds != 0) $display("FAIL feed_pending got %0d expected 0", feeds); else n_pass++;
        box_present = 1'b1;
        tick();
        n_checks++; if (state !== 2'd2) $display("FAIL fill_state got %0d expected 2", state); else n_pass++;
        n_checks++; if (hold !== 1'b0) $display("FAIL fill_hold got %0d expected 0", hold); else n_pass++;
        do_box();
    endtask

    task automatic test_no_stock();
        int feeds;
        stock_load = 1'b1; stock_in = 5'd0;
        tick();
        stock_load = 1'b0;
        n_checks++; if (al_caixa !== 1'b1) $display("FAIL nostock_alarm got %0d expected 1", al_caixa); else n_pass++;
        feeds = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (box_feed === 1'b1) feeds++;
        end
        n_checks++; if (feeds != 0) $display("FAIL nostock_feed got %0d expected 0", feeds); else n_pass++;
        n_checks++; if (box_stock !== 5'd0) $display("FAIL nostock_stock got %0d expected 0", box_stock); else n_pass++;
        stock_load = 1'b1; stock_in = 5'd25;
        tick();
        stock_load = 1'b0;
        n_checks++; if (box_stock !== 5'd20) $display("FAIL load_sat got %0d expected 20", box_stock); else n_pass++;
        n_checks++; if (al_caixa !== 1'b0) $display("FAIL load_alarm got %0d expected 0", al_caixa); else n_pass++;
        n_checks++; if (box_feed !== 1'b0) $display("FAIL load_defer got %0d expected 0", box_feed); else n_pass++;
        tick();
        n_checks++; if (box_feed !== 1'b1) $display("FAIL deferred_feed got %0d expected 1", box_feed); else n_pass++;
        n_checks++; if (box_stock !== 5'd19) $display("FAIL deferred_stock got %0d expected 19", box_stock); else n_pass++;
    endtask

    task automatic test_err_drop();
        bottle_in = 1'b1;
        tick();
        n_checks++; if (err_drop !== 1'b1) $display("FAIL err_load got %0d expected 1", err_drop); else n_pass++;
        n_checks++; if (bottle_count !== 4'd0) $display("FAIL err_load_count got %0d expected 0", bottle_count); else n_pass++;
        bottle_in = 1'b0;
        tick();
        box_present = 1'b1;
        tick();
        fill_bottles(1, 5);
        box_present = 1'b0;
        tick();
        n_checks++; if (state !== 2'd1) $display("FAIL lost_state got %0d expected 1", state); else n_pass++;
        n_checks++; if (bottle_count !== 4'd5) $display("FAIL lost_count got %0d expected 5", bottle_count); else n_pass++;
        box_present = 1'b1;
        tick();
        n_checks++; if (state !== 2'd2) $display("FAIL refill_state got %0d expected 2", state); else n_pass++;
        fill_bottles(6, 12);
        tick();
        bottle_in = 1'b1;
        tick();
        n_checks++; if (bottle_count !== 4'd12) $display("FAIL err_eject_count got %0d expected 12", bottle_count); else n_pass++;
        n_checks++; if (err_drop !== 1'b1) $display("FAIL err_sticky got %0d expected 1", err_drop); else n_pass++;
        bottle_in = 1'b0;
        repeat (8) tick();
        complete_box();
        n_checks++; if (box_stock !== 5'd19) $display("FAIL lost_stock got %0d expected 19", box_stock); else n_pass++;
    endtask

    task automatic test_enable_pause();
        int hi;
        box_present = 1'b1;
        tick();
        fill_bottles(1, 12);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) enable = 1'b0;
            if (k == 6) enable = 1'b1;
            #1;
            if (k == 4) begin
                n_checks++; if (state !== 2'd3) $display("FAIL pause_state got %0d expected 3", state); else n_pass++;
                n_checks++; if ({hold, box_eject} !== 2'b10) $display("FAIL pause_outputs got %b expected 10", {hold, box_eject}); else n_pass++;
            end
            if (box_eject === 1'b1) hi++;
            tick();
        end
        n_checks++; if (hi != 4) $display("FAIL pause_width got %0d expected 4", hi); else n_pass++;
        complete_box();
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 120 && m_boxes != 99; b++) do_box();
        n_checks++; if (box_count !== 7'd99) $display("FAIL wrap_pre got %0d expected 99", box_count); else n_pass++;
        do_box();
        n_checks++; if (box_count !== 7'd0) $display("FAIL wrap_zero got %0d expected 0", box_count); else n_pass++;
    endtask

    task automatic test_timeout();
        box_present = 1'b1;
        tick();
        fill_bottles(1, 12);
        repeat (70) tick();
        n_checks++; if (state !== 2'd3) $display("FAIL to_state got %0d expected 3", state); else n_pass++;
`ifdef CAIXA_TIMEOUT_EN
        n_checks++; if ({al_caixa, box_eject} !== 2'b11) $display("FAIL to_alarm got %b expected 11", {al_caixa, box_eject}); else n_pass++;
`else
        n_checks++; if ({al_caixa, box_eject} !== 2'b00) $display("FAIL to_alarm got %b expected 00", {al_caixa, box_eject}); else n_pass++;
`endif
        complete_box();
        n_checks++; if (al_caixa !== 1'b0) $display("FAIL to_clear got %0d expected 0", al_caixa); else n_pass++;
    endtask

    task automatic test_rst_clears();
        n_checks++; if (err_drop !== 1'b1) $display("FAIL err_before_rst got %0d expected 1", err_drop); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (err_drop !== 1'b0) $display("FAIL err_after_rst got %0d expected 0", err_drop); else n_pass++;
        n_checks++; if (state !== 2'd0) $display("FAIL rst2_state got %0d expected 0", state); else n_pass++;
        n_checks++; if ({box_count, box_stock} !== 12'd0) $display("FAIL rst2_counters got %0d expected 0", {box_count, box_stock}); else n_pass++;
        n_checks++; if (hold !== 1'b1) $display("FAIL rst2_hold got %0d expected 1", hold); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_feed_and_fill();
        test_no_stock();
        test_err_drop();
        test_enable_pause();
        test_wrap();
        test_timeout();
        test_rst_clears();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
